// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_op_t;

    // Bits needed to count the WIDTH/2 partial-product steps.
    function automatic int count_width(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: one multiplier triplet selects 0, +/-M or +/-2M.
module booth_recode
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]         triplet,
    input  logic [2*WIDTH-1:0] mcand,
    output logic [2*WIDTH-1:0] pp
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] ONE = PW'(1);

    booth_op_t       op;
    logic [PW-1:0]   mcand_x2;

    assign mcand_x2 = {mcand[PW-2:0], 1'b0};

    // Decode the triplet into a signed-digit operation.
    always_comb begin
        op = ZERO;
        case (triplet)
            3'b001, 3'b010: op = POS1;
            3'b011:         op = POS2;
            3'b100:         op = NEG2;
            3'b101, 3'b110: op = NEG1;
            default:        op = ZERO;
        endcase
    end

    // Form the partial product; negation wraps at 2*WIDTH bits.
    always_comb begin
        pp = '0;
        case (op)
            POS1:    pp = mcand;
            POS2:    pp = mcand_x2;
            NEG1:    pp = ~mcand + ONE;
            NEG2:    pp = ~mcand_x2 + ONE;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier: one partial product per cycle into a
// shared accumulator, valid/ready on both sides.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] s,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

    booth_state_t  state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [WIDTH:0] mreg_q, mreg_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] s_q, s_d;

    logic [PW-1:0] pp;
    logic [PW-1:0] pp_shift;
    logic [PW-1:0] sum;

    booth_recode #(.WIDTH(WIDTH)) u_recode (
        .triplet (mreg_q[2:0]),
        .mcand   (mcand_q),
        .pp      (pp)
    );

    // Weight of partial product i is 4^i; the single adder closes the loop.
    assign pp_shift = pp << {count_q, 1'b0};
    assign sum      = acc_q + pp_shift;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;

    // Next-state logic: accept, step through the triplets, hold until consumed.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        mreg_d  = mreg_q;
        acc_d   = acc_q;
        s_d     = s_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    mcand_d = {{WIDTH{a[WIDTH-1]}}, a};
                    mreg_d  = {b, 1'b0};
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            CALC: begin
                acc_d   = sum;
                mreg_d  = {{2{mreg_q[WIDTH]}}, mreg_q[WIDTH:2]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = DONE;
                    s_d     = sum;
                end
            end
            DONE: begin
                // Operands offered in this cycle are not taken; in_ready is low.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            mcand_q <= '0;
            mreg_q  <= '0;
            acc_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            mreg_q  <= mreg_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
        end
    end

endmodule
